// File: rtl/cam_init_seq.sv
// Camera bring-up sequencer: powers the sensor, steps it out of reset, then
// releases and triggers the I2C register writer, retrying on timeout.
module cam_init_seq #(
    parameter int unsigned PWUP_CYCLES    = 20_000,
    parameter int unsigned BOOT_CYCLES    = 20_000,
    parameter int unsigned TIMEOUT_CYCLES = 100_000,
    parameter int unsigned MAX_RETRIES    = 2,
    localparam int unsigned RET_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             i2c_done_i,
    output logic             i2c_trig_o,
    output logic             i2c_rst_o,
    output logic             cam_pwr_en_o,
    output logic             cam_rst_n_o,
    output logic             ready_o,
    output logic             error_o,
    output logic [RET_W-1:0] retries_o
);

    localparam int unsigned MAX_AB  = (PWUP_CYCLES > BOOT_CYCLES) ? PWUP_CYCLES : BOOT_CYCLES;
    localparam int unsigned MAX_CYC = (MAX_AB > TIMEOUT_CYCLES) ? MAX_AB : TIMEOUT_CYCLES;
    localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0] PWUP_LAST    = CNT_W'(PWUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] BOOT_LAST    = CNT_W'(BOOT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [RET_W-1:0] RETRY_LIMIT  = RET_W'(MAX_RETRIES);

    localparam logic [2:0] ST_OFF       = 3'd0;
    localparam logic [2:0] ST_PWR_WAIT  = 3'd1;
    localparam logic [2:0] ST_BOOT_WAIT = 3'd2;
    localparam logic [2:0] ST_TRIG      = 3'd3;
    localparam logic [2:0] ST_CFG_WAIT  = 3'd4;
    localparam logic [2:0] ST_READY     = 3'd5;
    localparam logic [2:0] ST_FAULT     = 3'd6;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [RET_W-1:0] retry_q, retry_d;

    logic             i2c_trig_q, i2c_trig_d;
    logic             i2c_rst_q, i2c_rst_d;
    logic             cam_pwr_en_q, cam_pwr_en_d;
    logic             cam_rst_n_q, cam_rst_n_d;
    logic             ready_q, ready_d;
    logic             error_q, error_d;
    logic [RET_W-1:0] retries_q, retries_d;

    logic timed_state;

    // NOTE: every variable gets a default at the top of always_comb so no path
    // leaves it unassigned; a missing default would infer a latch.
    always_comb begin
        state_d = state_q;
        retry_d = retry_q;

        case (state_q)
            ST_OFF: begin
                if (en_i) state_d = ST_PWR_WAIT;
            end
            ST_PWR_WAIT: begin
                if (cnt_q == PWUP_LAST) state_d = ST_BOOT_WAIT;
            end
            ST_BOOT_WAIT: begin
                if (cnt_q == BOOT_LAST) state_d = ST_TRIG;
            end
            ST_TRIG: begin
                state_d = ST_CFG_WAIT;
            end
            ST_CFG_WAIT: begin
                // Done beats the timeout when both land in the same cycle.
                if (i2c_done_i) begin
                    state_d = ST_READY;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    if (retry_q < RETRY_LIMIT) begin
                        retry_d = retry_q + RET_W'(1);
                        state_d = ST_PWR_WAIT;
                    end else begin
                        state_d = ST_FAULT;
                    end
                end
            end
            ST_READY: state_d = ST_READY;
            ST_FAULT: state_d = ST_FAULT;
            default:  state_d = ST_OFF;
        endcase

        if (!en_i) state_d = ST_OFF;
        if (state_d == ST_OFF) retry_d = '0;
    end

    assign timed_state = (state_q == ST_PWR_WAIT) || (state_q == ST_BOOT_WAIT) ||
                         (state_q == ST_CFG_WAIT);

    always_comb begin
        cnt_d = timed_state ? cnt_q + CNT_W'(1) : '0;
        if (state_d != state_q) cnt_d = '0;
    end

    // Outputs are decoded from the current state and registered, so no input
    // reaches a pin combinationally.
    always_comb begin
        i2c_trig_d   = 1'b0;
        i2c_rst_d    = 1'b1;
        cam_pwr_en_d = 1'b0;
        cam_rst_n_d  = 1'b0;
        ready_d      = 1'b0;
        error_d      = 1'b0;
        retries_d    = retry_q;

        case (state_q)
            ST_PWR_WAIT: begin
                cam_pwr_en_d = 1'b1;
            end
            ST_BOOT_WAIT: begin
                cam_pwr_en_d = 1'b1;
                cam_rst_n_d  = 1'b1;
            end
            ST_TRIG: begin
                cam_pwr_en_d = 1'b1;
                cam_rst_n_d  = 1'b1;
                i2c_rst_d    = 1'b0;
                i2c_trig_d   = 1'b1;
            end
            ST_CFG_WAIT: begin
                cam_pwr_en_d = 1'b1;
                cam_rst_n_d  = 1'b1;
                i2c_rst_d    = 1'b0;
            end
            ST_READY: begin
                cam_pwr_en_d = 1'b1;
                cam_rst_n_d  = 1'b1;
                i2c_rst_d    = 1'b0;
                ready_d      = 1'b1;
            end
            ST_FAULT: begin
                error_d = 1'b1;
            end
            default: begin
                i2c_rst_d = 1'b1;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_OFF;
            cnt_q        <= '0;
            retry_q      <= '0;
            i2c_trig_q   <= 1'b0;
            i2c_rst_q    <= 1'b1;
            cam_pwr_en_q <= 1'b0;
            cam_rst_n_q  <= 1'b0;
            ready_q      <= 1'b0;
            error_q      <= 1'b0;
            retries_q    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            retry_q      <= retry_d;
            i2c_trig_q   <= i2c_trig_d;
            i2c_rst_q    <= i2c_rst_d;
            cam_pwr_en_q <= cam_pwr_en_d;
            cam_rst_n_q  <= cam_rst_n_d;
            ready_q      <= ready_d;
            error_q      <= error_d;
            retries_q    <= retries_d;
        end
    end

    assign i2c_trig_o   = i2c_trig_q;
    assign i2c_rst_o    = i2c_rst_q;
    assign cam_pwr_en_o = cam_pwr_en_q;
    assign cam_rst_n_o  = cam_rst_n_q;
    assign ready_o      = ready_q;
    assign error_o      = error_q;
    assign retries_o    = retries_q;

endmodule

// File: tb/tb_cam_init_seq.sv
// Directed bench for cam_init_seq with short delays: PWUP=4, BOOT=3,
// TIMEOUT=10, MAX_RETRIES=1. Outputs are sampled 1 time unit after each rising edge.
module tb_cam_init_seq;

    logic       clk_i;
    logic       rst_i;
    logic       en_i;
    logic       i2c_done_i;
    logic       i2c_trig_o;
    logic       i2c_rst_o;
    logic       cam_pwr_en_o;
    logic       cam_rst_n_o;
    logic       ready_o;
    logic       error_o;
    logic [0:0] retries_o;

    int checks;
    int failures;

    // {trig, i2c_rst, pwr, rst_n, ready, error, retries}
    logic [6:0] obs;
    logic [6:0] exp_v;

    localparam logic [6:0] V_OFF   = 7'b0100000;
    localparam logic [6:0] V_PWR   = 7'b0110000;
    localparam logic [6:0] V_BOOT  = 7'b0111000;
    localparam logic [6:0] V_TRIG  = 7'b1011000;
    localparam logic [6:0] V_CFG   = 7'b0011000;
    localparam logic [6:0] V_READY = 7'b0011100;
    localparam logic [6:0] V_FAULT = 7'b0100010;

    assign obs = {i2c_trig_o, i2c_rst_o, cam_pwr_en_o, cam_rst_n_o, ready_o, error_o, retries_o};

    cam_init_seq #(
        .PWUP_CYCLES   (4),
        .BOOT_CYCLES   (3),
        .TIMEOUT_CYCLES(10),
        .MAX_RETRIES   (1)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .en_i        (en_i),
        .i2c_done_i  (i2c_done_i),
        .i2c_trig_o  (i2c_trig_o),
        .i2c_rst_o   (i2c_rst_o),
        .cam_pwr_en_o(cam_pwr_en_o),
        .cam_rst_n_o (cam_rst_n_o),
        .ready_o     (ready_o),
        .error_o     (error_o),
        .retries_o   (retries_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Outputs seen j edges after the edge that first samples en_i=1,
    // with no done and no retry so far.
    function automatic logic [6:0] bringup_vec(input int j);
        if (j <= 0)      return V_OFF;
        else if (j <= 4) return V_PWR;
        else if (j <= 7) return V_BOOT;
        else if (j == 8) return V_TRIG;
        else             return V_CFG;
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic apply_reset();
        en_i       = 1'b0;
        i2c_done_i = 1'b0;
        rst_i      = 1'b1;
        #2;
        rst_i      = 1'b0;
    endtask

    task automatic test_reset();
        en_i       = 1'b1;
        i2c_done_i = 1'b0;
        rst_i      = 1'b0;
        #1;
        rst_i      = 1'b1;
        #1;
        checks++;
        if (obs !== V_OFF) begin
            failures++;
            $display("FAIL reset_async: got %b expected %b", obs, V_OFF);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (obs !== V_OFF) begin
                failures++;
                $display("FAIL reset_hold cycle=%0d: got %b expected %b", i, obs, V_OFF);
            end
        end
        rst_i = 1'b0;
        tick();
        checks++;
        if (obs !== V_OFF) begin
            failures++;
            $display("FAIL reset_edge0: got %b expected %b", obs, V_OFF);
        end
        tick();
        checks++;
        if (obs !== V_PWR) begin
            failures++;
            $display("FAIL reset_edge1_pwr: got %b expected %b", obs, V_PWR);
        end
        en_i = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_nominal();
        apply_reset();
        en_i = 1'b1;
        for (int k = 0; k <= 17; k++) begin
            tick();
            if (k <= 14)      exp_v = bringup_vec(k);
            else if (k <= 16) exp_v = V_READY;
            else              exp_v = V_OFF;
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL nominal k=%0d: got %b expected %b", k, obs, exp_v);
            end
            if (k == 13) i2c_done_i = 1'b1;
            if (k == 15) begin
                en_i       = 1'b0;
                i2c_done_i = 1'b0;
            end
        end
    endtask

    task automatic test_timeout_retry();
        apply_reset();
        en_i = 1'b1;
        for (int k = 0; k <= 42; k++) begin
            tick();
            if (k <= 18)      exp_v = bringup_vec(k);
            else if (k <= 36) exp_v = bringup_vec(k - 18) | 7'b0000001;
            else if (k <= 41) exp_v = V_FAULT | 7'b0000001;
            else              exp_v = V_OFF;
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL timeout_retry k=%0d: got %b expected %b", k, obs, exp_v);
            end
            if (k == 40) en_i = 1'b0;
        end
    endtask

    task automatic test_abort();
        apply_reset();
        en_i = 1'b1;
        for (int k = 0; k <= 17; k++) begin
            tick();
            if (k <= 6)      exp_v = bringup_vec(k);
            else if (k == 7) exp_v = V_OFF;
            else             exp_v = bringup_vec(k - 8);
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL abort k=%0d: got %b expected %b", k, obs, exp_v);
            end
            if (k == 5) en_i = 1'b0;
            if (k == 7) en_i = 1'b1;
        end
        en_i = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_done_timeout_collision();
        apply_reset();
        en_i = 1'b1;
        for (int k = 0; k <= 20; k++) begin
            tick();
            exp_v = (k <= 18) ? bringup_vec(k) : V_READY;
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL collision k=%0d: got %b expected %b", k, obs, exp_v);
            end
            if (k == 17) i2c_done_i = 1'b1;
        end
        en_i       = 1'b0;
        i2c_done_i = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_async_reset();
        apply_reset();
        en_i = 1'b1;
        for (int k = 0; k <= 12; k++) begin
            tick();
            exp_v = bringup_vec(k);
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL async_pre k=%0d: got %b expected %b", k, obs, exp_v);
            end
        end
        #2;
        rst_i = 1'b1;
        #1;
        checks++;
        if (obs !== V_OFF) begin
            failures++;
            $display("FAIL async_assert: got %b expected %b", obs, V_OFF);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (obs !== V_OFF) begin
                failures++;
                $display("FAIL async_hold cycle=%0d: got %b expected %b", i, obs, V_OFF);
            end
        end
        rst_i = 1'b0;
        en_i  = 1'b0;
        tick();
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        rst_i      = 1'b0;
        en_i       = 1'b0;
        i2c_done_i = 1'b0;
        test_reset();
        test_nominal();
        test_timeout_retry();
        test_abort();
        test_done_timeout_collision();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/cam_init_seq.md
# cam_init_seq

Camera bring-up sequencer that sits directly upstream of the I2C register writer. It powers the image sensor, holds and releases the sensor hardware reset with fixed delays, then releases the writer from reset and fires its one-cycle trigger. It waits for the writer's done flag, retries on timeout, and reports ready or fault to the MIPI receive path.

## Interface
- PWUP_CYCLES, 20_000: cycles the sensor is powered with reset held low (≥1).
- BOOT_CYCLES, 20_000: cycles after reset release before I2C configuration (≥1).
- TIMEOUT_CYCLES, 100_000: maximum cycles to wait for i2c_done_i per attempt (≥1).
- MAX_RETRIES, 2: extra configuration attempts after the first timeout (≥0).
- clk_i  in  1  clock.
- rst_i  in  1  reset; asynchronous, active-high.
- en_i  in  1  level; 1 = bring camera up, 0 = power down.
- i2c_done_i  in  1  writer done level.
- i2c_trig_o  out  1  one-cycle trigger to writer.
- i2c_rst_o  out  1  writer reset; active-high.
- cam_pwr_en_o  out  1  sensor power enable.
- cam_rst_n_o  out  1  sensor hardware reset; active-low.
- ready_o  out  1  configuration complete.
- error_o  out  1  retries exhausted.
- retries_o  out  $clog2(MAX_RETRIES+1) (min 1)  number of retries used.

## Operation
- States: OFF, PWR_WAIT, BOOT_WAIT, TRIG, CFG_WAIT, READY, FAULT. Reset state is OFF.
- All outputs are decoded from registered state only; there is no combinational input-to-output path.
- OFF: pwr=0, rst_n=0, i2c_rst=1. Counter and retry count are cleared. If en_i=1, go to PWR_WAIT.
- PWR_WAIT: pwr=1, rst_n=0, i2c_rst=1. After PWUP_CYCLES cycles, go to BOOT_WAIT.
- BOOT_WAIT: pwr=1, rst_n=1, i2c_rst=1. After BOOT_CYCLES cycles, go to TRIG.
- TRIG: i2c_rst=0, i2c_trig=1. Lasts exactly one cycle, then go to CFG_WAIT.
- CFG_WAIT: i2c_rst=0.
  - i2c_done_i=1 → READY.
  - Otherwise, on the TIMEOUT_CYCLES-th cycle:
    - if retry count < MAX_RETRIES: increment it and go to PWR_WAIT (sensor reset re-asserted, writer re-reset, power held).
    - else go to FAULT.
- READY: ready_o=1, pwr=1, rst_n=1, i2c_rst=0. Stays until en_i=0.
- FAULT: error_o=1, pwr=0, rst_n=0, i2c_rst=1. Stays until en_i=0.
- en_i=0 in any state except OFF → OFF on the next edge. This overrides all other transitions.
- Counter behaviour:
  - Cleared on every state entry.
  - Increments each cycle in timed states.
  - The exit condition is cnt == N-1, so each timed state lasts exactly N cycles.
  - Width is $clog2 of the largest of the three cycle parameters (min 1).
- retries_o holds its value in READY and FAULT. It is cleared only in OFF.

## Timing
- Reset values: i2c_trig_o=0, i2c_rst_o=1, cam_pwr_en_o=0, cam_rst_n_o=0, ready_o=0, error_o=0, retries_o=0.
- Edge 0 samples en_i=1. cam_pwr_en_o rises after edge 1.
- cam_rst_n_o rises PWUP_CYCLES cycles after cam_pwr_en_o.
- i2c_trig_o is high for exactly one cycle, BOOT_CYCLES cycles after cam_rst_n_o rises.
- i2c_rst_o falls in the same cycle that i2c_trig_o is high. The writer's async reset is therefore released before the trigger edge.
- i2c_done_i sampled high → ready_o high after the next edge.
- If done arrives in the timeout cycle, done wins and the block goes to READY.
- The writer is only re-triggerable via reset. Every retry passes through PWR_WAIT, where i2c_rst_o=1 for ≥PWUP_CYCLES cycles.
- rst_i asserted mid-sequence forces the reset values immediately, without waiting for a clock edge.

## Test plan
Bench parameters: PWUP=4, BOOT=3, TIMEOUT=10, MAX_RETRIES=1.
- Reset check: assert rst_i with en_i=1 → all outputs at reset values. Release → pwr rises 1 cycle after the first edge sampling en_i.
- Nominal bring-up: en_i=1, done driven 5 cycles after trig → pwr high, rst_n low for 4 cycles, then rst_n high; trig pulse 3 cycles later (1 cycle wide, i2c_rst_o low); ready_o=1 on the cycle after done; retries_o=0.
- Timeout and retry: done never driven → after 10 CFG_WAIT cycles rst_n=0, i2c_rst_o=1, retries_o=1. Second timeout → error_o=1, pwr=0, no third trig. en_i=0 → OFF, retries_o=0.
- Abort: drop en_i during BOOT_WAIT → next cycle pwr=0, rst_n=0, i2c_rst=1. Re-enable → full 4+3 cycle sequence restarts.
- Done/timeout collision: done asserted exactly in the 10th CFG_WAIT cycle → READY, retries_o=0.
- Async reset mid-CFG_WAIT → outputs at reset values before the next clock edge; no trig pulse emitted.
